rasterizer_triangle_scheduler: RTL

Sequences triangles into the rasterizer.
- Buffers incoming triangle descriptors in a small FIFO behind a valid/ready interface.
- Issues a one-cycle go pulse with stable vertex coordinates and waits for the rasterizer's done pulse.
- Enforces a watchdog timeout so a hung rasterizer cannot stall the queue.
- Sits between the scene/geometry front end and the rasterizer; drops out-of-range triangles and keeps status counters.

---
 rtl/rasterizer_triangle_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rasterizer_triangle_scheduler.sv
// Queues triangles and hands them one at a time to the rasterizer: go two cycles after accept, next go three cycles after done.
// Backpressure: o_tri_ready drops while the queue is full; a watchdog frees the queue if the rasterizer never finishes.
module rasterizer_triangle_scheduler #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 8192,
  localparam int XW  = $clog2(HORIZ_RESOLUTION),
  localparam int YW  = $clog2(VERT_RESOLUTION),
  localparam int CW  = $clog2(FIFO_DEPTH) + 1,
  localparam int AW  = $clog2(FIFO_DEPTH),
  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic          i_clk,
  input  logic          i_srst,
  input  logic          i_tri_valid,
  output logic          o_tri_ready,
  input  logic [XW-1:0] i_tri_p0_x,
  input  logic [XW-1:0] i_tri_p1_x,
  input  logic [XW-1:0] i_tri_p2_x,
  input  logic [YW-1:0] i_tri_p0_y,
  input  logic [YW-1:0] i_tri_p1_y,
  input  logic [YW-1:0] i_tri_p2_y,
  output logic          o_go,
  output logic [XW-1:0] o_p0_x,
  output logic [XW-1:0] o_p1_x,
  output logic [XW-1:0] o_p2_x,
  output logic [YW-1:0] o_p0_y,
  output logic [YW-1:0] o_p1_y,
  output logic [YW-1:0] o_p2_y,
  input  logic          i_raster_done,
  output logic          o_busy,
  output logic [CW-1:0] o_fifo_count,
  output logic [15:0]   o_tri_count,
  output logic [7:0]    o_drop_count,
  output logic          o_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COOLDOWN} state_t;

  typedef struct packed {
    logic [XW-1:0] p0_x;
    logic [YW-1:0] p0_y;
    logic [XW-1:0] p1_x;
    logic [YW-1:0] p1_y;
    logic [XW-1:0] p2_x;
    logic [YW-1:0] p2_y;
  } tri_t;

  tri_t           mem [FIFO_DEPTH];
  tri_t           in_tri;
  tri_t           head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [WDW-1:0] wd;
  state_t         state;
  state_t         next_state;
  logic           in_range;
  logic           accept;
  logic           push;
  logic           pop;
  logic           drop;
  logic           done_ok;
  logic           wd_expired;

  always_comb begin
    in_tri      = '0;
    in_tri.p0_x = i_tri_p0_x;
    in_tri.p0_y = i_tri_p0_y;
    in_tri.p1_x = i_tri_p1_x;
    in_tri.p1_y = i_tri_p1_y;
    in_tri.p2_x = i_tri_p2_x;
    in_tri.p2_y = i_tri_p2_y;
  end

  // Compare in int width so non-power-of-two resolutions are checked exactly.
  assign in_range = (int'(i_tri_p0_x) < HORIZ_RESOLUTION) &&
                    (int'(i_tri_p1_x) < HORIZ_RESOLUTION) &&
                    (int'(i_tri_p2_x) < HORIZ_RESOLUTION) &&
                    (int'(i_tri_p0_y) < VERT_RESOLUTION)  &&
                    (int'(i_tri_p1_y) < VERT_RESOLUTION)  &&
                    (int'(i_tri_p2_y) < VERT_RESOLUTION);

  assign o_tri_ready  = (count < CW'(FIFO_DEPTH));
  assign accept       = i_tri_valid && o_tri_ready;
  assign push         = accept && in_range;
  assign drop         = accept && !in_range;
  assign head         = mem[rd_ptr];
  assign o_fifo_count = count;
  assign o_busy       = (state != IDLE) || (count != '0);
  assign wd_expired   = (wd == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    o_go       = 1'b0;
    o_timeout  = 1'b0;
    done_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        o_go       = 1'b1;
        next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done landing on the expiry cycle still counts as a completion.
        if (i_raster_done) begin
          done_ok    = 1'b1;
          next_state = COOLDOWN;
        end else if (wd_expired) begin
          o_timeout  = 1'b1;
          next_state = COOLDOWN;
        end
      end
      COOLDOWN: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= in_tri;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wd           <= '0;
      o_p0_x       <= '0;
      o_p0_y       <= '0;
      o_p1_x       <= '0;
      o_p1_y       <= '0;
      o_p2_x       <= '0;
      o_p2_y       <= '0;
      o_tri_count  <= '0;
      o_drop_count <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        o_p0_x <= head.p0_x;
        o_p0_y <= head.p0_y;
        o_p1_x <= head.p1_x;
        o_p1_y <= head.p1_y;
        o_p2_x <= head.p2_x;
        o_p2_y <= head.p2_y;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (state == ISSUE) wd <= '0;
      else if (state == WAIT_DONE) wd <= wd + WDW'(1);
      if (done_ok) o_tri_count <= o_tri_count + 16'd1;
      if (drop && (o_drop_count != 8'hFF)) o_drop_count <= o_drop_count + 8'd1;
    end
  end

endmodule
